// File: rtl/ql_carry_chain_pipe.sv
// ql_carry_chain_pipe: P/G carry chain split into SEG-bit register stages with input skew and output deskew.
module ql_carry_chain_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] G,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUMOUT,
  output logic             CO
);
  localparam int NSTG = (WIDTH + SEG - 1) / SEG;
  assign IN_READY = ~OUT_VALID | OUT_READY;
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int HI = (((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH) - 1;
    // One word register per stage: bits below HI+1 hold sums (deskew), bits above hold pending P (skew).
    logic [WIDTH-1:0] pin, w_d, w_q;
    logic [WIDTH-1:LO] gin;
    logic cin, vin, c_d, c_q, v_q;
    if (k == 0) begin : g_in
      assign pin = P;
      assign gin = G;
      assign cin = CI;
      assign vin = IN_VALID;
    end else begin : g_in
      assign pin = g_stg[k-1].w_q;
      assign gin = g_stg[k-1].g_sk.g_q;
      assign cin = g_stg[k-1].c_q;
      assign vin = g_stg[k-1].v_q;
    end
    always_comb begin
      w_d = pin;
      c_d = cin;
      for (int i = LO; i <= HI; i++) begin
        w_d[i] = pin[i] ^ c_d;
        c_d = pin[i] ? c_d : gin[i];
      end
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        w_q <= '0;
      end else if (IN_READY) begin
        v_q <= vin;
        c_q <= c_d;
        w_q <= w_d;
      end
    end
    if (k < NSTG - 1) begin : g_sk
      logic [WIDTH-1:HI+1] g_q;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) g_q <= '0;
        else if (IN_READY) g_q <= gin[WIDTH-1:HI+1];
      end
    end
  end
  assign OUT_VALID = g_stg[NSTG-1].v_q;
  assign SUMOUT    = g_stg[NSTG-1].w_q;
  assign CO        = g_stg[NSTG-1].c_q;
endmodule

// File: tb/tb_ql_carry_chain_pipe.sv
// tb_ql_carry_chain_pipe: three configurations (8/4, 13/5, 8/8) driven in lockstep, scoreboard per instance.
module tb_ql_carry_chain_pipe;
  localparam int N  = 3;
  localparam int MW = 13;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic rst_n;
  logic [MW-1:0] p[N], g[N], sum[N], exp_s[N];
  logic ci[N], iv[N], ir[N], ov[N], ordy[N], co[N], exp_c[N];
  int compared = 0, mismatched = 0;
  logic run;

  function automatic int w_of(input int j);
    return (j == 1) ? 13 : 8;
  endfunction

  function automatic logic [MW:0] mk(input int w);
    logic [MW:0] one;
    one = 1;
    return (one << w) - 1;
  endfunction

  // {carry, sum}: P/G re-expressed as an addition of a=P|Ge and b=Ge, with Ge=G&~P.
  function automatic logic [MW:0] model(input int w, input logic [MW-1:0] pv, gv, input logic cv);
    logic [MW:0] m, pe, ge;
    m  = mk(w);
    pe = {1'b0, pv} & m;
    ge = {1'b0, gv & ~pv} & m;
    return (pe | ge) + ge + {{MW{1'b0}}, cv};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  for (genvar j = 0; j < N; j++) begin : g_d
    localparam int W = (j == 1) ? 13 : 8;
    localparam int S = (j == 0) ? 4 : (j == 1) ? 5 : 8;
    localparam int NSTG = (W + S - 1) / S;
    typedef struct {
      logic [MW-1:0] s;
      logic c;
      int a;
      int st;
    } ent_t;
    logic [W-1:0] s;
    ent_t q[$];
    ent_t e;
    int n = 0, st = 0;
    logic pstall = 1'b0, pco;
    logic [MW-1:0] psum;
    ql_carry_chain_pipe #(.WIDTH(W), .SEG(S)) dut (
      .CLK(CLK), .RESET_N(rst_n), .IN_VALID(iv[j]), .IN_READY(ir[j]),
      .P(p[j][W-1:0]), .G(g[j][W-1:0]), .CI(ci[j]),
      .OUT_VALID(ov[j]), .OUT_READY(ordy[j]), .SUMOUT(s), .CO(co[j])
    );
    assign sum[j] = MW'(s);
    always @(negedge CLK) begin
      n++;
      if (!rst_n) begin
        q.delete();
        pstall = 1'b0;
      end else begin
        if (iv[j] && ir[j]) q.push_back('{exp_s[j], exp_c[j], n, st});
        if (pstall) begin
          check($sformatf("hold_sum%0d", j), 32'(sum[j]), 32'(psum));
          check($sformatf("hold_co%0d", j), 32'(co[j]), 32'(pco));
        end
        check($sformatf("in_ready%0d", j), 32'(ir[j]), ov[j] ? 32'(ordy[j]) : 32'd1);
        if (ov[j] && ordy[j]) begin
          if (q.size() == 0) check($sformatf("unexpected_out%0d", j), 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            check($sformatf("sum%0d", j), 32'(sum[j]), 32'(e.s));
            check($sformatf("co%0d", j), 32'(co[j]), 32'(e.c));
            check($sformatf("latency%0d", j), 32'(n - e.a - (st - e.st)), 32'(NSTG));
          end
        end
        pstall = ov[j] && !ordy[j];
        if (pstall) st++;
        psum = sum[j];
        pco = co[j];
      end
    end
  end

  task automatic send(input logic [MW-1:0] pv, gv, input logic cv, input logic [7:0] es, input logic ec, input logic tab);
    logic [MW:0] r;
    logic done[N];
    int t;
    for (int j = 0; j < N; j++) begin
      r = model(w_of(j), pv, gv, cv);
      p[j] = pv & mk(w_of(j))[MW-1:0];
      g[j] = gv & mk(w_of(j))[MW-1:0];
      ci[j] = cv;
      exp_s[j] = (tab && w_of(j) == 8) ? MW'(es) : r[MW-1:0] & mk(w_of(j))[MW-1:0];
      exp_c[j] = (tab && w_of(j) == 8) ? ec : r[w_of(j)];
      iv[j] = 1'b1;
      done[j] = 1'b0;
    end
    t = 0;
    while (!(done[0] && done[1] && done[2]) && t < 200) begin
      @(negedge CLK);
      for (int j = 0; j < N; j++) if (iv[j] && ir[j]) done[j] = 1'b1;
      @(posedge CLK);
      #1;
      for (int j = 0; j < N; j++) if (done[j]) iv[j] = 1'b0;
      t++;
    end
    if (t >= 200) begin
      check("send_timeout", 32'd0, 32'd1);
      for (int j = 0; j < N; j++) iv[j] = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] p, g;
    logic c;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t dir[8] = '{
    '{8'h0E, 8'h01, 1'b0, 8'h10, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1},
    '{8'hFE, 8'h01, 1'b0, 8'h00, 1'b1},
    '{8'h01, 8'h01, 1'b1, 8'h02, 1'b0},
    '{8'h00, 8'h01, 1'b0, 8'h02, 1'b0},
    '{8'h7E, 8'h01, 1'b0, 8'h80, 1'b0},
    '{8'h00, 8'h80, 1'b0, 8'h00, 1'b1},
    '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0}
  };

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    for (int j = 0; j < N; j++) begin
      iv[j] = 1'b1;
      p[j] = MW'($urandom) & mk(w_of(j))[MW-1:0];
      g[j] = MW'($urandom) & mk(w_of(j))[MW-1:0];
      ci[j] = 1'b1;
      ordy[j] = 1'b1;
      exp_s[j] = '0;
      exp_c[j] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    for (int j = 0; j < N; j++) begin
      check($sformatf("rst_out_valid%0d", j), 32'(ov[j]), 32'd0);
      check($sformatf("rst_sum%0d", j), 32'(sum[j]), 32'd0);
      check($sformatf("rst_co%0d", j), 32'(co[j]), 32'd0);
      check($sformatf("rst_in_ready%0d", j), 32'(ir[j]), 32'd1);
      iv[j] = 1'b0;
    end
    @(posedge CLK);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 8; i++) send(MW'(dir[i].p), MW'(dir[i].g), dir[i].c, dir[i].s, dir[i].co, 1'b1);
    repeat (4) @(posedge CLK);
    #1;
    fork
      for (int i = 0; i < 8; i++) send(MW'($urandom), MW'($urandom), 1'($urandom), 8'h0, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge CLK);
        #1 for (int j = 0; j < N; j++) ordy[j] = 1'b0;
        repeat (3) @(posedge CLK);
        #1 for (int j = 0; j < N; j++) ordy[j] = 1'b1;
      end
    join
    for (int i = 0; i < 2; i++) send(MW'($urandom), MW'($urandom), 1'($urandom), 8'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int j = 0; j < N; j++) begin
      check($sformatf("midrst_out_valid%0d", j), 32'(ov[j]), 32'd0);
      check($sformatf("midrst_sum%0d", j), 32'(sum[j]), 32'd0);
    end
    @(posedge CLK);
    #1 rst_n = 1'b1;
    run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) send(MW'($urandom), MW'($urandom), 1'($urandom), 8'h0, 1'b0, 1'b0);
        run = 1'b0;
      end
      while (run) begin
        @(posedge CLK);
        #1 for (int j = 0; j < N; j++) ordy[j] = run ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    join
    for (int j = 0; j < N; j++) ordy[j] = 1'b1;
    repeat (10) @(negedge CLK);
    check("drain0", 32'(g_d[0].q.size()), 32'd0);
    check("drain1", 32'(g_d[1].q.size()), 32'd0);
    check("drain2", 32'(g_d[2].q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ql_carry_chain_pipe.md
Name: ql_carry_chain_pipe

Overview:
- Parametrised, pipelined carry chain built from the propagate/generate bit cell: per bit SUM = P ^ c_in, c_out = P ? c_in : G.
- Splits a WIDTH-bit chain into segments of SEG bits, with a register boundary after each segment, so long adders/counters in the fabric meet timing.
- Uses a valid/ready handshake with a global stall. Output sum bits are deskewed so the whole word emerges aligned.

Parameters:
- WIDTH, 16, chain length in bits (>=1).
- SEG, 4, bits per pipeline segment (1..WIDTH). NSTG = ceil(WIDTH/SEG) is derived; the last segment may be partial.

Ports:
- CLK  input  1  clock, all flops rising-edge.
- RESET_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  input word valid.
- IN_READY  output  1  pipeline can accept; transfer when IN_VALID & IN_READY.
- P  input  WIDTH  propagate vector.
- G  input  WIDTH  generate vector.
- CI  input  1  chain carry-in.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts; transfer when OUT_VALID & OUT_READY.
- SUMOUT  output  WIDTH  sum word, aligned.
- CO  output  1  final carry-out (carry out of bit WIDTH-1).

Behaviour:
- Reset (async assert, sync-safe deassert by the user): all stage valids = 0, all data/carry/skew registers = 0. OUT_VALID = 0, SUMOUT = 0, CO = 0, IN_READY = 1.
- Bit cell: G is ignored when P = 1 (mux semantics). P = G = 1 is legal and behaves as propagate.
- Stage k (0..NSTG-1) computes segment bits [k*SEG, min((k+1)*SEG, WIDTH)-1] combinationally from its carry input and registers:
  - its sum bits;
  - the segment carry-out;
  - a valid bit.
- Carry input: stage 0 uses CI; stage k>0 uses the carry register of stage k-1.
- Skew: P/G for segment k travel through k input-skew register levels before stage k consumes them. Sum bits of segment k travel through NSTG-1-k output-deskew levels. All bits of one word therefore reach SUMOUT in the same cycle.
- Latency: NSTG cycles from accepted input to OUT_VALID, with no stalls. Throughput is one word per cycle.
- Stall rule: advance = ~OUT_VALID | OUT_READY; IN_READY = advance (combinational).
  - When advance = 0, every pipeline register (data, carry, valid) holds.
  - When advance = 1, all registers shift one level. Stage 0 loads IN_VALID & IN_READY, which is always IN_VALID in this case.
- Bubbles: an invalid slot propagates with valid = 0. Its data contents are don't-care but must not be X after reset (registers are reset).
- OUT_VALID, SUMOUT and CO are registered outputs driven from the final stage. SUMOUT/CO hold stable while OUT_VALID & ~OUT_READY.
- CO is the carry register of stage NSTG-1, aligned with SUMOUT.
- Degenerate case SEG >= WIDTH: NSTG = 1, latency 1, no skew registers.
- Reset mid-operation: in-flight words are discarded immediately. OUT_VALID drops asynchronously. No partial word emerges after release.
- Simultaneous OUT_READY deassert and new IN_VALID: the input is not accepted (IN_READY = 0) and the upstream must hold it.

Test Plan (WIDTH=8, SEG=4 unless noted; NSTG=2, latency 2):
- Reset: assert RESET_N=0 with IN_VALID=1 and random P/G. Required: OUT_VALID=0, SUMOUT=0x00, CO=0, IN_READY=1. After release, the first result appears only 2 cycles after the first accepted word.
- Addition 0x0F+0x01 (P=0x0E, G=0x01, CI=0), OUT_READY=1 → 2 cycles later SUMOUT=0x10, CO=0. This checks the cross-segment carry through the stage register.
- Full propagate P=0xFF, G=0x00, CI=1 → SUMOUT=0x00, CO=1. Then 0xFF+0x01 (P=0xFE, G=0x01, CI=0) → SUMOUT=0x00, CO=1.
- Back-to-back stream of 4 words (e.g. 0x01+0x01, 0x7F+0x01, 0x80+0x80, 0x55+0xAA) with OUT_READY=1 → results 0x02/0, 0x80/0, 0x00/1, 0xFF/0 on 4 consecutive cycles, in order.
- Backpressure: hold OUT_READY=0 for 3 cycles while the stream continues → IN_READY=0 for those cycles. SUMOUT/CO remain stable. No word is lost or duplicated, and the order is preserved after OUT_READY=1.
- Parameter sweep WIDTH=13, SEG=5 (NSTG=3, partial last segment) and WIDTH=8, SEG=8: run a random P/G/CI stream with random OUT_READY and compare against a reference model. Latency must be 3 and 1 respectively.
